single_to_int: RTL and testbench

- Converts an IEEE-754 single-precision value to a signed 32-bit two's-complement integer.
- Rounds toward zero (C cast semantics).
- Inverse companion of the integer-to-single converter; uses the same stb/ack handshake on both sides, so the two blocks chain directly.
- Multi-cycle iterative datapath with one conversion in flight at a time.

---
 rtl/single_to_int.sv | 119 +++++++++++
 tb/tb_single_to_int.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_to_int.sv
// IEEE-754 single to signed 32-bit integer converter, truncating toward zero.
// Iterative shifter, one operand in flight, stb/ack handshake on both sides.
module single_to_int (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] single_val,
  input  logic        single_stb,
  output logic        single_ack,
  output logic [31:0] int_val,
  output logic        int_stb,
  input  logic        int_ack
);

  // state          | meaning
  // st_get_single  | ready for an operand, single_ack high
  // st_unpack      | split fields, detect zero and saturation
  // st_convert     | shift mantissa right one bit per cycle until e reaches 31
  // st_pack        | apply sign to the shifted magnitude
  // st_put_int     | present result until the consumer acknowledges
  typedef enum logic [2:0] {
    st_get_single,
    st_unpack,
    st_convert,
    st_pack,
    st_put_int
  } state_t;

  state_t      state, state_d;
  logic [31:0] a, a_d;
  logic [31:0] m, m_d;
  logic [9:0]  e, e_d;
  logic        z_s, z_s_d;
  logic [31:0] int_val_d;
  logic        int_stb_d;
  logic        single_ack_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= st_get_single;
      a          <= '0;
      m          <= '0;
      e          <= '0;
      z_s        <= 1'b0;
      int_val    <= '0;
      int_stb    <= 1'b0;
      single_ack <= 1'b0;
    end else begin
      state      <= state_d;
      a          <= a_d;
      m          <= m_d;
      e          <= e_d;
      z_s        <= z_s_d;
      int_val    <= int_val_d;
      int_stb    <= int_stb_d;
      single_ack <= single_ack_d;
    end
  end

  always_comb begin
    state_d      = state;
    a_d          = a;
    m_d          = m;
    e_d          = e;
    z_s_d        = z_s;
    int_val_d    = int_val;
    int_stb_d    = int_stb;
    single_ack_d = single_ack;

    case (state)
      st_get_single: begin
        single_ack_d = 1'b1;
        if (single_ack && single_stb) begin
          a_d          = single_val;
          single_ack_d = 1'b0;
          state_d      = st_unpack;
        end
      end

      st_unpack: begin
        z_s_d = a[31];
        e_d   = {2'b00, a[30:23]} - 10'd127;
        m_d   = {1'b1, a[22:0], 8'h00};
        // Biased exponent below 127 means |x| < 1 (also covers zero and denormals).
        if (a[30:23] == 8'd0 || a[30:23] < 8'd127) begin
          m_d     = '0;
          state_d = st_pack;
        end else if (a[30:23] > 8'd157) begin
          int_val_d = 32'h8000_0000;
          state_d   = st_put_int;
        end else begin
          state_d = st_convert;
        end
      end

      st_convert: begin
        m_d = m >> 1;
        e_d = e + 10'd1;
        // Leave on the shift that takes e from 30 to 31, saving a cycle.
        if (e == 10'd30) state_d = st_pack;
      end

      st_pack: begin
        int_val_d = z_s ? (~m + 32'd1) : m;
        state_d   = st_put_int;
      end

      st_put_int: begin
        int_stb_d = 1'b1;
        if (int_stb && int_ack) begin
          int_stb_d = 1'b0;
          state_d   = st_get_single;
        end
      end

      default: state_d = st_get_single;
    endcase
  end

endmodule

// File: tb/tb_single_to_int.sv
// Directed and random checks for single_to_int against a truncating reference.
module tb_single_to_int;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] single_val = '0;
  logic        single_stb = 1'b0;
  logic        single_ack;
  logic [31:0] int_val;
  logic        int_stb;
  logic        int_ack = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  single_to_int dut (
    .clk        (clk),
    .rst        (rst),
    .single_val (single_val),
    .single_stb (single_stb),
    .single_ack (single_ack),
    .int_val    (int_val),
    .int_stb    (int_stb),
    .int_ack    (int_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_conv(input logic [31:0] f);
    logic [7:0]  ex;
    logic [31:0] mag;
    int          sh;
    ex = f[30:23];
    if (ex < 8'd127) return 32'd0;
    if (ex > 8'd157) return 32'h8000_0000;
    mag = {8'h00, 1'b1, f[22:0]};
    sh  = int'(ex) - 127;
    if (sh >= 23) mag = mag << (sh - 23);
    else          mag = mag >> (23 - sh);
    return f[31] ? (32'd0 - mag) : mag;
  endfunction

  function automatic int ref_lat(input logic [31:0] f);
    int ex;
    ex = int'(f[30:23]);
    if (ex < 127) return 3;
    if (ex > 157) return 2;
    return 3 + (31 - (ex - 127));
  endfunction

  // Present an operand and return one step after the accept edge.
  task automatic send(input logic [31:0] v, output bit ok);
    int n;
    ok = 1'b0;
    @(negedge clk);
    single_val = v;
    single_stb = 1'b1;
    for (n = 0; n < 100; n++) begin
      if (single_ack === 1'b1) begin
        @(posedge clk);
        #1;
        single_stb = 1'b0;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      single_stb = 1'b0;
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: single_ack not seen for operand %08h", v);
    end
  endtask

  // Count edges from accept until int_stb is seen high.
  task automatic wait_result(output logic [31:0] r, output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    r   = '0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      lat++;
      if (int_stb === 1'b1) begin
        r  = int_val;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL result_timeout: int_stb not seen after %0d cycles", lat);
    end
  endtask

  task automatic ack_result();
    int_ack = 1'b1;
    @(posedge clk);
    #1;
    int_ack = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (single_ack !== 1'b0 || int_stb !== 1'b0 || int_val !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b stb=%b val=%08h, required 0 0 00000000",
               single_ack, int_stb, int_val);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (single_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: single_ack=%b, required 1", single_ack);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] vec [11];
    logic [31:0] want [11];
    logic [31:0] r;
    int          lat;
    bit          ok;
    vec = '{32'h3F80_0000, 32'hC049_0FDB, 32'h4EFF_FFFF, 32'h3F00_0000, 32'hBF7F_FFFF,
            32'h8000_0000, 32'h0000_0001, 32'h4F00_0000, 32'hCF00_0000, 32'h7F80_0000,
            32'h7FC0_0000};
    want = '{32'h0000_0001, 32'hFFFF_FFFD, 32'h7FFF_FF80, 32'd0, 32'd0,
             32'd0, 32'd0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
             32'h8000_0000};
    for (int i = 0; i < 11; i++) begin
      send(vec[i], ok);
      if (!ok) continue;
      wait_result(r, lat, ok);
      if (!ok) continue;
      n_tests++;
      if (r !== want[i]) begin
        n_fail++;
        $display("FAIL vec_value[%0d]: in=%08h got=%08h required=%08h", i, vec[i], r, want[i]);
      end
      n_tests++;
      if (lat != ref_lat(vec[i])) begin
        n_fail++;
        $display("FAIL vec_latency[%0d]: in=%08h got=%0d required=%0d",
                 i, vec[i], lat, ref_lat(vec[i]));
      end
      ack_result();
    end
  endtask

  task automatic test_latency();
    logic [31:0] r;
    int          lat;
    bit          ok;
    send(32'h3F80_0000, ok);
    wait_result(r, lat, ok);
    n_tests++;
    if (lat != 34) begin
      n_fail++;
      $display("FAIL latency_e0: got=%0d required=34", lat);
    end
    ack_result();
    send(32'h4F00_0000, ok);
    wait_result(r, lat, ok);
    n_tests++;
    if (lat != 2) begin
      n_fail++;
      $display("FAIL latency_sat: got=%0d required=2", lat);
    end
    ack_result();
  endtask

  task automatic test_back_pressure();
    logic [31:0] r;
    int          lat;
    bit          ok;
    send(32'hC049_0FDB, ok);
    wait_result(r, lat, ok);
    if (!ok) return;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (int_stb !== 1'b1 || int_val !== 32'hFFFF_FFFD || single_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: stb=%b val=%08h ack=%b, required 1 FFFFFFFD 0",
                 i, int_stb, int_val, single_ack);
      end
    end
    ack_result();
    n_tests++;
    if (int_stb !== 1'b0 || single_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: stb=%b ack=%b, required 0 0", int_stb, single_ack);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (single_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready: single_ack=%b, required 1", single_ack);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int          lat;
    bit          ok;
    bit          stale;
    send(32'h3F80_0000, ok);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_tests++;
    if (single_ack !== 1'b0 || int_stb !== 1'b0 || int_val !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: ack=%b stb=%b val=%08h, required 0 0 00000000",
               single_ack, int_stb, int_val);
    end
    @(negedge clk);
    rst = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (int_stb !== 1'b0) stale = 1'b1;
    end
    n_tests++;
    if (stale) begin
      n_fail++;
      $display("FAIL reset_stale: int_stb seen after reset, required none");
    end
    send(32'h4120_0000, ok);
    wait_result(r, lat, ok);
    n_tests++;
    if (r !== 32'h0000_000A) begin
      n_fail++;
      $display("FAIL reset_next: got=%08h required=0000000A", r);
    end
    ack_result();
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic [31:0] r;
    int          lat;
    bit          ok;
    int          errs;
    errs = 0;
    for (int i = 0; i < 2000; i++) begin
      v = $urandom;
      if (i % 2 == 0) v[30:23] = 8'($urandom_range(127, 158));
      send(v, ok);
      if (!ok) break;
      wait_result(r, lat, ok);
      if (!ok) break;
      n_tests++;
      if (r !== ref_conv(v)) begin
        n_fail++;
        errs++;
        if (errs < 10)
          $display("FAIL stream[%0d]: in=%08h got=%08h required=%08h", i, v, r, ref_conv(v));
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      ack_result();
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_latency();
    test_back_pressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
